n64_paddle_tracker: RTL

Polls the N64 controller interface at a fixed rate, captures each 34-bit report on `readValid`, and decodes the button field and the analog stick axes. It integrates stick Y deflection into a saturated paddle position for the ping-pong game logic. It sits directly downstream of the N64 controller receiver and drives that receiver's `start` input. Missing responses are tracked and reported as link status.

---
 rtl/n64_pkg.sv | 24 ++
 rtl/n64_paddle_integrator.sv | 41 ++++
 rtl/n64_paddle_tracker.sv | 108 ++++++++++
 3 files changed

// File: rtl/n64_pkg.sv
// Shared types and report layout for the N64 paddle tracker.
package n64_pkg;

  typedef enum logic [1:0] {IDLE, POLL, WAIT, UPDATE} trackState_t;

  localparam int BTN_BASE = 0;
  localparam int X_MSB    = 16;
  localparam int Y_MSB    = 24;
  localparam int REPORT_W = 34;

  // Declared MSB first, so a is bit 0 and cr is bit 15.
  typedef struct packed {
    logic cr, cl, cd, cu, r, l, rsv1, rsv0;
    logic dr, dl, dd, du, start, z, b, a;
  } btn_t;

  // Axis bytes arrive MSB first, so the lowest report index is the sign bit.
  function automatic logic [7:0] revByte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/n64_paddle_integrator.sv
// Next paddle position from stick Y: deadzone, shift, clamp, Start recentre.
// Optional D-pad nudging inside the deadzone when N64_PADDLE_DPAD_EN is defined.
module n64_paddle_integrator import n64_pkg::*; #(
  parameter int DEADZONE    = 8,
  parameter int SPEED_SHIFT = 3,
  parameter int PADDLE_MIN  = 0,
  parameter int PADDLE_MAX  = 400,
  parameter int PADDLE_INIT = 200,
  parameter int DPAD_STEP   = 2
) (
  input  logic [9:0]        curPos,
  input  logic signed [7:0] stickY,
  input  btn_t              btn,
  output logic [9:0]        nextPos
);

  logic [8:0]        mag, step;
  logic signed [10:0] sum;
  logic              unusedBtn;

  assign unusedBtn = ^{btn, 10'(DPAD_STEP)};

  always_comb begin
    // 9-bit magnitude so -128 maps to 128 rather than wrapping.
    mag  = stickY[7] ? (9'd0 - {1'b1, stickY}) : {1'b0, stickY};
    step = (mag - 9'(DEADZONE)) >> SPEED_SHIFT;
    if (step == '0) step = 9'd1;
    sum = signed'({1'b0, curPos});
    if (mag > 9'(DEADZONE))
      sum = stickY[7] ? sum + signed'({2'b0, step}) : sum - signed'({2'b0, step});
`ifdef N64_PADDLE_DPAD_EN
    else if (btn.du != btn.dd)
      sum = btn.du ? sum - 11'(DPAD_STEP) : sum + 11'(DPAD_STEP);
`endif
    if (btn.start)                  nextPos = 10'(PADDLE_INIT);
    else if (int'(sum) < PADDLE_MIN) nextPos = 10'(PADDLE_MIN);
    else if (int'(sum) > PADDLE_MAX) nextPos = 10'(PADDLE_MAX);
    else                            nextPos = sum[9:0];
  end

endmodule

// File: rtl/n64_paddle_tracker.sv
// Polls the N64 receiver, decodes reports and integrates stick Y into a paddle position.
// Optional D-pad movement: define N64_PADDLE_DPAD_EN.
module n64_paddle_tracker import n64_pkg::*; #(
  parameter int POLL_PERIOD    = 166667,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int DEADZONE       = 8,
  parameter int SPEED_SHIFT    = 3,
  parameter int PADDLE_MIN     = 0,
  parameter int PADDLE_MAX     = 400,
  parameter int PADDLE_INIT    = 200,
  parameter int DPAD_STEP      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [REPORT_W-1:0] data,
  input  logic                readValid,
  output logic                start,
  output logic [15:0]         buttons,
  output logic signed [7:0]   stickX,
  output logic signed [7:0]   stickY,
  output logic [9:0]          paddlePos,
  output logic                updateValid,
  output logic                linkUp,
  output logic [3:0]          missCount
);

  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  trackState_t       state;
  logic [PW-1:0]     periodCnt;
  logic [TW-1:0]     toCnt;
  logic              rvPrev, tick;
  logic [31:0]       report;
  logic signed [7:0] rptY;
  btn_t              rptBtn;
  logic [9:0]        nextPos;
  logic              unusedBits;

  assign tick       = (periodCnt == PW'(POLL_PERIOD - 1));
  assign rptY       = signed'(revByte(report[Y_MSB +: 8]));
  assign rptBtn     = btn_t'(report[BTN_BASE +: 16]);
  assign unusedBits = ^data[REPORT_W-1:32];

  n64_paddle_integrator #(
    .DEADZONE(DEADZONE), .SPEED_SHIFT(SPEED_SHIFT), .PADDLE_MIN(PADDLE_MIN),
    .PADDLE_MAX(PADDLE_MAX), .PADDLE_INIT(PADDLE_INIT), .DPAD_STEP(DPAD_STEP)
  ) uInteg (
    .curPos(paddlePos), .stickY(rptY), .btn(rptBtn), .nextPos(nextPos)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      periodCnt   <= '0;
      toCnt       <= '0;
      rvPrev      <= 1'b0;
      report      <= '0;
      start       <= 1'b0;
      buttons     <= '0;
      stickX      <= '0;
      stickY      <= '0;
      paddlePos   <= 10'(PADDLE_INIT);
      updateValid <= 1'b0;
      linkUp      <= 1'b0;
      missCount   <= '0;
    end else begin
      rvPrev      <= readValid;
      periodCnt   <= tick ? '0 : periodCnt + 1'b1;
      start       <= 1'b0;
      updateValid <= 1'b0;
      case (state)
        IDLE: if (tick && enable) begin
          state <= POLL;
          start <= 1'b1;
        end
        POLL: begin
          state <= WAIT;
          toCnt <= '0;
        end
        // A report edge beats a timeout landing in the same cycle.
        WAIT: if (readValid && !rvPrev) begin
          report <= data[31:0];
          state  <= UPDATE;
        end else if (toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          missCount <= (missCount == 4'd15) ? 4'd15 : missCount + 4'd1;
          if (missCount >= 4'd2) linkUp <= 1'b0;
        end else begin
          toCnt <= toCnt + 1'b1;
        end
        UPDATE: begin
          state       <= IDLE;
          buttons     <= report[BTN_BASE +: 16];
          stickX      <= signed'(revByte(report[X_MSB +: 8]));
          stickY      <= rptY;
          paddlePos   <= nextPos;
          updateValid <= 1'b1;
          linkUp      <= 1'b1;
          missCount   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
